// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with registered read data, occupancy count
// and almost-full / almost-empty threshold flags.
//
// The occupancy flags and the count are decoded from the pointer registers
// only, so nothing combinational runs from wr_en_fifo/rd_en_fifo to them.
//
// Optional feature: define SYNC_FIFO_ERR_EN to add the sticky overflow_fifo and
// underflow_fifo error outputs. The default build leaves the macro undefined
// and has neither those ports nor their logic.

module sync_fifo_buf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk_fifo,
    input  logic                  rst_fifo,

    input  logic                  wr_en_fifo,
    input  logic [DATA_WIDTH-1:0] wr_data_fifo,

    input  logic                  rd_en_fifo,
    output logic [DATA_WIDTH-1:0] rd_data_fifo,
    output logic                  rd_valid_fifo,

    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic [ADDR_WIDTH:0]   count_fifo
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow_fifo,
    output logic                  underflow_fifo
`endif
);

    // Thresholds narrowed to the width of the count so the compares match in width.
    localparam logic [ADDR_WIDTH:0] AfLevel = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeLevel = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PtrOne  = 1;

    // Storage. It is deliberately left unreset, because stale words can only
    // be read back after they have been rewritten.
    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    // Each pointer carries one extra wrap bit, so full and empty can be told apart.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  full_s;
    logic                  empty_s;
    logic [ADDR_WIDTH:0]   count_s;

    // Occupancy decode from the registered pointers only.
    always_comb begin
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        count_s = wr_ptr_q - rd_ptr_q;
    end

    // Acceptance: full blocks writes even with a read in the same cycle (no
    // pass-through); empty blocks reads even with a write in the same cycle.
    always_comb begin
        wr_accept = wr_en_fifo && !full_s;
        rd_accept = rd_en_fifo && !empty_s;
    end

    // Next-state values for the pointers and the read-data register.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + PtrOne;
            rd_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_valid_d = 1'b1;
        end
    end

    // Pointer and read-data state. Reset overrides any request at the same edge.
    always_ff @(posedge clk_fifo) begin
        if (rst_fifo) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Memory write port. It is suppressed during reset so that reset wins outright.
    always_ff @(posedge clk_fifo) begin
        if (!rst_fifo && wr_accept) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_fifo;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags. They record any request that the full or empty state
    // rejected, and only reset clears them.
    always_ff @(posedge clk_fifo) begin
        if (rst_fifo) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en_fifo && full_s) begin
                overflow_q <= 1'b1;
            end
            if (rd_en_fifo && empty_s) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Error outputs.
    always_comb begin
        overflow_fifo  = overflow_q;
        underflow_fifo = underflow_q;
    end
`endif

    // Output mapping.
    always_comb begin
        rd_data_fifo      = rd_data_q;
        rd_valid_fifo     = rd_valid_q;
        full_fifo         = full_s;
        empty_fifo        = empty_s;
        count_fifo        = count_s;
        almost_full_fifo  = (count_s >= AfLevel);
        almost_empty_fifo = (count_s <= AeLevel);
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Testbench for sync_fifo_buf (default parameters, SYNC_FIFO_ERR_EN undefined).
// Directed scenarios are followed by random traffic. A queue-based model of
// FIFO behaviour supplies every expected value.

module tb_sync_fifo_buf;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;

    logic          clk_fifo;
    logic          rst_fifo;
    logic          wr_en_fifo;
    logic [DW-1:0] wr_data_fifo;
    logic          rd_en_fifo;
    logic [DW-1:0] rd_data_fifo;
    logic          rd_valid_fifo;
    logic          full_fifo;
    logic          empty_fifo;
    logic          almost_full_fifo;
    logic          almost_empty_fifo;
    logic [AW:0]   count_fifo;

    sync_fifo_buf #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_fifo         (clk_fifo),
        .rst_fifo         (rst_fifo),
        .wr_en_fifo       (wr_en_fifo),
        .wr_data_fifo     (wr_data_fifo),
        .rd_en_fifo       (rd_en_fifo),
        .rd_data_fifo     (rd_data_fifo),
        .rd_valid_fifo    (rd_valid_fifo),
        .full_fifo        (full_fifo),
        .empty_fifo       (empty_fifo),
        .almost_full_fifo (almost_full_fifo),
        .almost_empty_fifo(almost_empty_fifo),
        .count_fifo       (count_fifo)
    );

    initial clk_fifo = 1'b0;
    always #5 clk_fifo = ~clk_fifo;

    // Reference model: the stored words in order, plus the expected read port.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_data;
    logic          m_valid;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = model_q.size();
        chk("count", 32'(count_fifo), 32'(n));
        chk("empty", 32'(empty_fifo), 32'(n == 0));
        chk("full", 32'(full_fifo), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full_fifo), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty_fifo), 32'(n <= AE));
        chk("rd_valid", 32'(rd_valid_fifo), 32'(m_valid));
        chk("rd_data", 32'(rd_data_fifo), 32'(m_data));
    endtask

    // One clock: drive on the falling edge, update the model, check just after the rising edge.
    task automatic step(input logic rst, input logic we, input logic [DW-1:0] wd,
                        input logic re);
        bit racc;
        bit wacc;
        @(negedge clk_fifo);
        rst_fifo     = rst;
        wr_en_fifo   = we;
        wr_data_fifo = wd;
        rd_en_fifo   = re;
        if (rst) begin
            model_q.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            racc    = re && (model_q.size() != 0);
            wacc    = we && (model_q.size() != DEPTH);
            m_valid = racc;
            if (racc) m_data = model_q.pop_front();
            if (wacc) model_q.push_back(wd);
        end
        @(posedge clk_fifo);
        #1;
        check_all();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        m_valid      = 1'b0;
        m_data       = '0;
        rst_fifo     = 1'b1;
        wr_en_fifo   = 1'b0;
        wr_data_fifo = '0;
        rd_en_fifo   = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b1);

        // Fill with 0x11..0x88.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'(8'h11 * i), 1'b0);
        end
        // Writing while full is dropped.
        step(1'b0, 1'b1, 8'h99, 1'b0);
        // Full and both requested: only the read is accepted.
        step(1'b0, 1'b1, 8'h9A, 1'b1);
        step(1'b0, 1'b1, 8'h9B, 1'b0);

        // Drain completely.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        // Empty read: no valid, data held.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        // Empty and both requested: only the write is accepted.
        step(1'b0, 1'b1, 8'h5A, 1'b1);

        // Bring the count to 4, then run simultaneous traffic across pointer wraps.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
        end

        // Reset in the middle of traffic at count 5, with a read accepted just before.
        step(1'b0, 1'b1, 8'hE1, 1'b1);
        step(1'b0, 1'b1, 8'hE2, 1'b0);
        step(1'b0, 1'b1, 8'hE3, 1'b1);
        step(1'b1, 1'b1, 8'hE4, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                 8'($urandom), ($urandom_range(0, 99) < 50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_buf.md
SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning depth exponent; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, meaning almost_full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning almost_empty threshold in words.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports: clk_fifo input 1 (sole clock, rising edge); rst_fifo input 1 (synchronous, active-high).
REQ-006 SHALL have wr_en_fifo input 1, write request.
REQ-007 SHALL have wr_data_fifo input DATA_WIDTH, write data.
REQ-008 SHALL have rd_en_fifo input 1, read request.
REQ-009 SHALL have rd_data_fifo output DATA_WIDTH, registered read data.
REQ-010 SHALL have rd_valid_fifo output 1, one-cycle pulse qualifying rd_data_fifo.
REQ-011 SHALL have full_fifo and empty_fifo outputs 1, occupancy flags.
REQ-012 SHALL have almost_full_fifo and almost_empty_fifo outputs 1, threshold flags.
REQ-013 SHALL have count_fifo output ADDR_WIDTH+1, current occupancy 0..DEPTH.

Function
REQ-014 SHALL accept a write on a clk_fifo edge iff wr_en_fifo=1 and full_fifo=0, storing wr_data_fifo at wr_ptr[ADDR_WIDTH-1:0].
REQ-015 SHALL accept a read iff rd_en_fifo=1 and empty_fifo=0; rd_data_fifo and rd_valid_fifo=1 SHALL appear the cycle after acceptance (latency 1).
REQ-016 SHALL hold rd_data_fifo unchanged when no read is accepted; rd_valid_fifo SHALL be 0 in that cycle.
REQ-017 SHALL keep wr_ptr and rd_ptr ADDR_WIDTH+1 bits wide, incrementing modulo 2**(ADDR_WIDTH+1); address wraps from DEPTH-1 to 0 without gaps.
REQ-018 SHALL derive empty_fifo = (wr_ptr == rd_ptr) and full_fifo = (address bits equal, MSBs differ), both registered-state-derived, no combinational path from wr_en/rd_en.
REQ-019 SHALL keep count_fifo = wr_ptr - rd_ptr; +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-020 SHALL, when full and both requested, accept only the read (write dropped that cycle; no pass-through).
REQ-021 SHALL, when empty and both requested, accept only the write; read data not available until a later request.
REQ-022 SHALL assert almost_full_fifo iff count_fifo >= AF_LEVEL and almost_empty_fifo iff count_fifo <= AE_LEVEL.
REQ-023 SHALL ignore rejected requests entirely: no pointer, count or memory change.
REQ-024 SHALL deliver words in strict write order across any number of wraps.

Reset
REQ-025 SHALL, while rst_fifo=1 at a clk_fifo edge, clear wr_ptr, rd_ptr, count_fifo to 0, rd_data_fifo to 0, rd_valid_fifo to 0; empty_fifo=1, almost_empty_fifo=1, full_fifo=0, almost_full_fifo=0 (AF_LEVEL>0).
REQ-026 SHALL NOT reset memory contents; contents are unobservable until rewritten.
REQ-027 SHALL give reset priority over simultaneous wr_en/rd_en; a read accepted the cycle before reset SHALL still not produce rd_valid_fifo in the reset cycle's following output if reset is asserted at that edge.

Configuration
REQ-028 SHALL, with SYNC_FIFO_ERR_EN defined, add outputs overflow_fifo and underflow_fifo (1 bit each, sticky): set on a rejected write when full / rejected read when empty, cleared only by rst_fifo.
REQ-029 SHALL, without SYNC_FIFO_ERR_EN, omit those ports and logic; all other behaviour identical.

Verification
REQ-030 Reset then 8 writes 0x11..0x88 (defaults) -> count_fifo 1..8, full_fifo=1 after 8th, almost_full_fifo=1 from 7th.
REQ-031 Full FIFO, write 0x99 -> dropped, count stays 8; with SYNC_FIFO_ERR_EN overflow_fifo=1 until reset.
REQ-032 8 reads after REQ-030 -> rd_data_fifo 0x11..0x88 each one cycle after rd_en_fifo with rd_valid_fifo=1; empty_fifo=1 after last.
REQ-033 Count 4, simultaneous write/read for 20 cycles -> count stays 4, order preserved across pointer wrap.
REQ-034 Empty, rd_en_fifo=1 -> no rd_valid_fifo, rd_data_fifo held; underflow_fifo=1 if enabled; empty+both -> count 1.
REQ-035 rst_fifo mid-traffic at count 5 -> next cycle count_fifo=0, empty_fifo=1, rd_valid_fifo=0, rd_data_fifo=0.
